instr_fetch: RTL and testbench

Instruction fetch unit for the LEGLite single-cycle datapath. It holds the architectural PC register and fetches each instruction from instruction memory with a request/acknowledge handshake. It presents the fetched instruction to decode and loads the PC-control logic's next-PC value once decode accepts the instruction. It consumes `pc_next` and drives `pc` back to the PC-control logic.

---
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// LEGLite instruction fetch: PC register, imem request/ack handshake, decode hand-off.
// Optional `INSTR_FETCH_ALIGN_CHECK_EN: an odd pc_next traps to ERR instead of being forced even.
module instr_fetch #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc_next,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  output logic        fetch_err
);

  typedef enum logic [1:0] {REQ, HOLD, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  assign imem_addr = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= REQ;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        REQ: begin
          // req is still low only in the first cycle after reset; raise it then
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= HOLD;
          end else if (wait_cnt == TO_LAST) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (instr_accept) begin
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            pc <= pc_next;
            if (pc_next[0]) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              imem_req <= 1'b1;
              state    <= REQ;
            end
`else
            pc       <= {pc_next[15:1], 1'b0};
            imem_req <= 1'b1;
            state    <= REQ;
`endif
          end
        end
        ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch/accept sequences with a scoreboard of
// expected {pc, instr} pairs popped when instr_valid rises.
module tb_instr_fetch;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc_next;
  logic [15:0] pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        fetch_err;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        vld_q = 1'b0;
  logic [15:0] exp_pc;
  int          n_chk = 0;
  int          n_err = 0;

  instr_fetch #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .pc_next(pc_next), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_accept(instr_accept), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; instr_accept = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    exp_pc = 16'h0000;
  endtask

  // Hold ack low for dly request cycles (req/addr must stay put), then ack with data.
  task automatic fetch(input int dly, input logic [15:0] data);
    for (int i = 0; i < dly; i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", {16'd0, imem_addr}, {16'd0, exp_pc});
      step();
    end
    chk("req_ack", {31'd0, imem_req}, 32'd1);
    chk("addr_ack", {16'd0, imem_addr}, {16'd0, exp_pc});
    imem_ack = 1'b1; imem_rdata = data;
    sb.push_back('{addr: exp_pc, data: data});
    step();
    imem_ack = 1'b0;
    chk("valid_rise", {31'd0, instr_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic accept(input logic [15:0] nxt);
    instr_accept = 1'b1; pc_next = nxt;
    step();
    instr_accept = 1'b0;
    exp_pc = {nxt[15:1], 1'b0};
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
    chk("acc_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  always @(negedge clock) begin
    if (instr_valid && !vld_q) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_instr", {16'd0, instr}, {16'd0, mon_e.data});
        chk("sb_pc", {16'd0, pc}, {16'd0, mon_e.addr});
      end
    end
    vld_q = instr_valid;
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; instr_accept = 1'b0;
    pc_next = 16'h0; imem_rdata = 16'h0; exp_pc = 16'h0;
    step(); step();
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;
    step();

    // zero-wait fetch at 0, then a 3-cycle-delayed fetch at 2
    fetch(0, 16'h1234);
    chk("instr_0", {16'd0, instr}, 32'h1234);
    step(); step();
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", {16'd0, instr}, 32'h1234);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    accept(16'h0002);
    fetch(3, 16'hBEEF);

    // branch backwards, then wrap-around
    accept(16'h0010);
    fetch(1, 16'h0A0A);
    accept(16'h0008);
    fetch(0, 16'h5555);
    accept(16'hFFFE);
    fetch(2, 16'hC3C3);
    accept(16'h0000);
    fetch(0, 16'h7E7E);

    // odd pc_next
    instr_accept = 1'b1; pc_next = 16'h0005;
    step();
    instr_accept = 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_pc", {16'd0, pc}, 32'h0005);
    step(); step();
    chk("mis_err_hold", {31'd0, fetch_err}, 32'd1);
    chk("mis_req_hold", {31'd0, imem_req}, 32'd0);
`else
    chk("mis_err", {31'd0, fetch_err}, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    chk("mis_addr", {16'd0, imem_addr}, 32'h0004);
    exp_pc = 16'h0004;
    fetch(1, 16'h4444);
`endif

    // timeout: TO unacked request cycles, then error; ack in ERR is ignored
    do_reset();
    chk("to_pc", {16'd0, pc}, 32'd0);
    for (int i = 1; i < TO; i++) step();
    chk("to_req_last", {31'd0, imem_req}, 32'd1);
    chk("to_err_early", {31'd0, fetch_err}, 32'd0);
    step();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    step(); step();
    imem_ack = 1'b0;
    chk("to_err_hold", {31'd0, fetch_err}, 32'd1);
    chk("to_valid_hold", {31'd0, instr_valid}, 32'd0);
    chk("to_req_hold", {31'd0, imem_req}, 32'd0);

    // reset clears error and restarts at 0
    do_reset();
    chk("rs_err", {31'd0, fetch_err}, 32'd0);
    fetch(0, 16'h1111);
    accept(16'h0020);

    // reset in the same cycle as ack wins
    imem_ack = 1'b1; imem_rdata = 16'h9999; reset = 1'b1;
    step();
    imem_ack = 1'b0; reset = 1'b0;
    chk("ra_valid", {31'd0, instr_valid}, 32'd0);
    chk("ra_pc", {16'd0, pc}, 32'd0);
    chk("ra_req", {31'd0, imem_req}, 32'd0);
    step();
    exp_pc = 16'h0000;
    chk("ra_req_restart", {31'd0, imem_req}, 32'd1);
    chk("ra_addr_restart", {16'd0, imem_addr}, 32'd0);
    fetch(0, 16'h2222);
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
